fizzbuzz_event_packer: RTL and testbench

- Downstream consumer of the fizz/buzz modulo stage.
- Samples the per-cycle fizz, buzz and fizzbuzz flags and classifies each cycle.
- Tags each hit with its cycle index and queues it in a small FIFO.
- Presents events on a valid/ready stream for a logger or UART stage, with overflow detection when the sink stalls.

---
 rtl/fizzbuzz_event_packer.sv | 213 +++++++++++++++++++++
 tb/tb_fizzbuzz_event_packer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fizzbuzz_event_packer.sv
// Classifies fizz/buzz flags per sample cycle, tags hits with the cycle index and queues them
// for a valid/ready sink. Define FBEP_STATS_EN to add per-code event counters.
module fizzbuzz_event_packer #(
  parameter int MAX_CYCLES = 100,
  parameter int DEPTH      = 4,
  parameter int DROP_W     = 8,
  localparam int IDXW      = $clog2(MAX_CYCLES)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_en,
  input  logic              fizz,
  input  logic              buzz,
  input  logic              fizzbuzz,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_code,
  output logic [IDXW-1:0]   out_index,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt,
  input  logic              clr_overflow
`ifdef FBEP_STATS_EN
  ,
  output logic [15:0]       stat_fizz,
  output logic [15:0]       stat_buzz,
  output logic [15:0]       stat_fizzbuzz
`endif
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int EW   = IDXW + 2;

  logic [IDXW-1:0]   idx_q, idx_d;
  logic [EW-1:0]     mem_q [DEPTH];
  logic [PTRW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic       event_s;
  logic [1:0] code_s;
  logic       full_s;
  logic       pop_s;
  logic       push_s;
  logic       drop_s;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    if (p == PTRW'(DEPTH - 1)) begin
      return {PTRW{1'b0}};
    end else begin
      return p + PTRW'(1);
    end
  endfunction

  // Classify the sample cycle; a set fizzbuzz flag or both single flags give code 3.
  always_comb begin
    event_s = 1'b0;
    code_s  = 2'd0;
    if (in_en) begin
      if (fizzbuzz || (fizz && buzz)) begin
        event_s = 1'b1;
        code_s  = 2'd3;
      end else if (fizz) begin
        event_s = 1'b1;
        code_s  = 2'd1;
      end else if (buzz) begin
        event_s = 1'b1;
        code_s  = 2'd2;
      end else begin
        event_s = 1'b0;
        code_s  = 2'd0;
      end
    end else begin
      event_s = 1'b0;
      code_s  = 2'd0;
    end
  end

  assign full_s = (count_q == CNTW'(DEPTH));
  assign pop_s  = (count_q != {CNTW{1'b0}}) && out_ready;
  assign push_s = event_s && (!full_s || pop_s);
  assign drop_s = event_s && full_s && !pop_s;

  always_comb begin
    idx_d      = idx_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (in_en) begin
      if (idx_q == IDXW'(MAX_CYCLES - 1)) begin
        idx_d = {IDXW{1'b0}};
      end else begin
        idx_d = idx_q + IDXW'(1);
      end
    end else begin
      idx_d = idx_q;
    end

    if (push_s) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase

    // A drop in the clearing cycle wins over the clear.
    if (clr_overflow) begin
      overflow_d = drop_s;
      drop_cnt_d = drop_s ? DROP_W'(1) : {DROP_W{1'b0}};
    end else if (drop_s) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != {DROP_W{1'b1}}) begin
        drop_cnt_d = drop_cnt_q + DROP_W'(1);
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end else begin
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx_q      <= {IDXW{1'b0}};
      wr_ptr_q   <= {PTRW{1'b0}};
      rd_ptr_q   <= {PTRW{1'b0}};
      count_q    <= {CNTW{1'b0}};
      overflow_q <= 1'b0;
      drop_cnt_q <= {DROP_W{1'b0}};
    end else begin
      idx_q      <= idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {EW{1'b0}};
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= {code_s, idx_q};
    end
  end

  assign out_valid = (count_q != {CNTW{1'b0}});
  assign out_code  = out_valid ? mem_q[rd_ptr_q][EW-1 -: 2] : 2'd0;
  assign out_index = out_valid ? mem_q[rd_ptr_q][IDXW-1:0] : {IDXW{1'b0}};
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

`ifdef FBEP_STATS_EN
  logic [15:0] stat_fizz_q, stat_fizz_d;
  logic [15:0] stat_buzz_q, stat_buzz_d;
  logic [15:0] stat_fizzbuzz_q, stat_fizzbuzz_d;

  function automatic logic [15:0] stat_next(input logic [15:0] cur, input logic hit,
                                            input logic clr);
    if (clr) begin
      return hit ? 16'd1 : 16'd0;
    end else if (hit && (cur != 16'hFFFF)) begin
      return cur + 16'd1;
    end else begin
      return cur;
    end
  endfunction

  // Every classified event counts, whether or not the FIFO had room for it.
  always_comb begin
    stat_fizz_d     = stat_next(stat_fizz_q, event_s && (code_s == 2'd1), clr_overflow);
    stat_buzz_d     = stat_next(stat_buzz_q, event_s && (code_s == 2'd2), clr_overflow);
    stat_fizzbuzz_d = stat_next(stat_fizzbuzz_q, event_s && (code_s == 2'd3), clr_overflow);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_fizz_q     <= 16'd0;
      stat_buzz_q     <= 16'd0;
      stat_fizzbuzz_q <= 16'd0;
    end else begin
      stat_fizz_q     <= stat_fizz_d;
      stat_buzz_q     <= stat_buzz_d;
      stat_fizzbuzz_q <= stat_fizzbuzz_d;
    end
  end

  assign stat_fizz     = stat_fizz_q;
  assign stat_buzz     = stat_buzz_q;
  assign stat_fizzbuzz = stat_fizzbuzz_q;
`endif

endmodule

// File: tb/tb_fizzbuzz_event_packer.sv
// Scoreboard bench for fizzbuzz_event_packer: directed test-plan sequences plus random traffic
// against a queue-based reference model.
module tb_fizzbuzz_event_packer;
  localparam int MAXC  = 100;
  localparam int DEPTH = 4;
  localparam int DW    = 8;

  logic clk = 1'b0;
  logic resetn, in_en, fizz, buzz, fizzbuzz, out_ready, clr_overflow;
  logic out_valid, overflow;
  logic [1:0] out_code;
  logic [6:0] out_index;
  logic [DW-1:0] drop_cnt;
`ifdef FBEP_STATS_EN
  logic [15:0] stat_fizz, stat_buzz, stat_fizzbuzz;
`endif

  fizzbuzz_event_packer #(.MAX_CYCLES(MAXC), .DEPTH(DEPTH), .DROP_W(DW)) dut (
    .clk(clk), .resetn(resetn), .in_en(in_en), .fizz(fizz), .buzz(buzz), .fizzbuzz(fizzbuzz),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code), .out_index(out_index),
    .overflow(overflow), .drop_cnt(drop_cnt), .clr_overflow(clr_overflow)
`ifdef FBEP_STATS_EN
    , .stat_fizz(stat_fizz), .stat_buzz(stat_buzz), .stat_fizzbuzz(stat_fizzbuzz)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] code;
    logic [6:0] idx;
  } ev_t;

  int  n_tests = 0;
  int  n_fail  = 0;
  ev_t exp_q[$];
  ev_t m_fifo[$];
  int  m_idx, m_drop;
  bit  m_ovf;
  bit  exp_valid, exp_ovf;
  int  exp_drop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_fifo.delete();
    m_idx = 0; m_drop = 0; m_ovf = 0;
    exp_valid = 0; exp_ovf = 0; exp_drop = 0;
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    in_en = 1'b0; fizz = 1'b0; buzz = 1'b0; fizzbuzz = 1'b0;
    out_ready = 1'b0; clr_overflow = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 resetn = 1'b1;
  endtask

  // Drive one sample cycle and advance the reference model by one clock.
  task automatic cycle(input bit en, input bit f, input bit b, input bit fb, input bit rdy,
                       input bit clr);
    bit  pop, dropped;
    ev_t e;
    in_en = en; fizz = f; buzz = b; fizzbuzz = fb; out_ready = rdy; clr_overflow = clr;
    exp_valid = (m_fifo.size() != 0);
    exp_ovf   = m_ovf;
    exp_drop  = m_drop;
    pop       = exp_valid && rdy;
    dropped   = 0;
    if (en && (f || b || fb)) begin
      e.code = (fb || (f && b)) ? 2'd3 : (f ? 2'd1 : 2'd2);
      e.idx  = 7'(m_idx);
      if (m_fifo.size() < DEPTH || pop) begin
        m_fifo.push_back(e);
        exp_q.push_back(e);
      end else begin
        dropped = 1;
      end
    end
    if (pop) void'(m_fifo.pop_front());
    if (clr) begin
      m_ovf  = dropped;
      m_drop = dropped ? 1 : 0;
    end else if (dropped) begin
      m_ovf = 1;
      if (m_drop < (1 << DW) - 1) m_drop++;
    end
    if (en) m_idx = (m_idx + 1) % MAXC;
    @(posedge clk);
    #1;
  endtask

  task automatic cycle_up(input bit rdy, input bit clr);
    cycle(1'b1, (m_idx % 3) == 0, (m_idx % 5) == 0, (m_idx % 15) == 0, rdy, clr);
  endtask

  // Monitor: compares the head entry and status against the scoreboard each cycle.
  always @(negedge clk) begin
    check("valid", out_valid, exp_valid);
    check("overflow", overflow, exp_ovf);
    check("drop_cnt", drop_cnt, exp_drop);
    check("idx_range", out_index < 7'd100, 1);
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", 1, 0);
      end else begin
        check("code", out_code, exp_q[0].code);
        check("index", out_index, exp_q[0].idx);
        if (out_ready === 1'b1) void'(exp_q.pop_front());
      end
    end else begin
      check("empty_code", out_code, 0);
      check("empty_index", out_index, 0);
    end
  end

  initial begin
    apply_reset();
    check("rst_valid", out_valid, 0);
    check("rst_code", out_code, 0);
    check("rst_index", out_index, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop", drop_cnt, 0);

    // Basic sequence and index wrap with the sink always ready.
    repeat (200) cycle_up(1'b1, 1'b0);

    // Backpressure: sink stalled for indices 0..15.
    apply_reset();
    repeat (16) cycle_up(1'b0, 1'b0);
    check("bp_overflow", overflow, 1);
    check("bp_drop", drop_cnt, 4);
    check("bp_retained", exp_q.size(), 4);
    repeat (6) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("bp_drained", exp_q.size(), 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("clr_overflow", overflow, 0);
    check("clr_drop", drop_cnt, 0);

    // Full FIFO with a pop in the same cycle as a fizz event (idx 9).
    apply_reset();
    repeat (9) cycle_up(1'b0, 1'b0);
    cycle_up(1'b1, 1'b0);
    check("fullpop_drop", drop_cnt, 0);
    check("fullpop_ovf", overflow, 0);
    repeat (6) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("fullpop_drained", exp_q.size(), 0);

    // in_en gating holds the index.
    apply_reset();
    repeat (7) cycle_up(1'b1, 1'b0);
    repeat (5) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("gate_valid", out_valid, 1);
    check("gate_idx", out_index, 7);
    check("gate_code", out_code, 1);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset with three entries queued.
    apply_reset();
    repeat (6) cycle_up(1'b0, 1'b0);
    check("pre_areset_q", exp_q.size(), 3);
    #2;
    resetn = 1'b0;
    in_en = 1'b0; out_ready = 1'b0;
    model_reset();
    #1;
    check("areset_valid", out_valid, 0);
    check("areset_code", out_code, 0);
    @(posedge clk);
    #3 resetn = 1'b1;
    cycle_up(1'b1, 1'b0);
    check("post_areset_valid", out_valid, 1);
    check("post_areset_idx", out_index, 0);
    check("post_areset_code", out_code, 3);
    repeat (20) cycle_up(1'b1, 1'b0);

    // Random traffic with varying sink readiness.
    apply_reset();
    for (int blk = 0; blk < 6; blk++) begin
      for (int i = 0; i < 400; i++) begin
        cycle(($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 3) == 0,
              ($urandom % 8) == 0, ($urandom % 6) < blk, ($urandom % 60) == 0);
      end
    end
    repeat (DEPTH + 4) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("final_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
